// File: rtl/coso_sequencer.sv
// coso_sequencer: run-time sequencer for one COSO TRNG instance.
// Holds the matching controller in reset until started, waits for a matched
// configuration, runs repetition-count and adaptive-proportion health tests
// on the raw bit stream, forwards passing bits while in RUN, restarts the
// search on health failures and raises a sticky alarm on fatal conditions.
//
// Output handshake: rndValid is a one-cycle strobe qualifying rndBit. There is
// no ready/backpressure; the consumer must accept every strobed bit.
module coso_sequencer #(
  parameter int RCTCutoff       = 8,
  parameter int APTWindowLog    = 6,
  parameter int APTCutoff       = 48,
  parameter int WarmupSamples   = 16,
  parameter int MatchTimeoutLog = 20,
  parameter int MaxRestarts     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       matched,
  input  logic       noFound,
  input  logic       bitValid,
  input  logic       bitIn,
  output logic       ctrlRst,
  output logic       rndValid,
  output logic       rndBit,
  output logic       alarm,
  output logic [1:0] alarmCode,
  output logic [2:0] state,
  output logic [1:0] restarts
);

  localparam int RctW = $clog2(RCTCutoff + 1);
  localparam int AptW = APTWindowLog + 1;
  localparam int WuW  = $clog2(WarmupSamples + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MATCH  = 3'd1,
    ST_WARMUP = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic                       ctrl_rst_q, ctrl_rst_d;
  logic                       rnd_valid_q, rnd_valid_d;
  logic                       rnd_bit_q, rnd_bit_d;
  logic                       alarm_q, alarm_d;
  logic [1:0]                 alarm_code_q, alarm_code_d;
  logic [1:0]                 restarts_q, restarts_d;
  logic [MatchTimeoutLog-1:0] tmo_q, tmo_d;
  logic                       have_prev_q, have_prev_d;
  logic                       prev_bit_q, prev_bit_d;
  logic [RctW-1:0]            rct_cnt_q, rct_cnt_d;
  logic [APTWindowLog-1:0]    apt_pos_q, apt_pos_d;
  logic                       apt_ref_q, apt_ref_d;
  logic [AptW-1:0]            apt_cnt_q, apt_cnt_d;
  logic [WuW-1:0]             wu_cnt_q, wu_cnt_d;

  logic [RctW-1:0]            rct_next;
  logic [AptW-1:0]            apt_next;
  logic                       in_test;
  logic                       health_fail;

  // Health-test counter values that the current bit would produce.
  always_comb begin
    in_test  = (state_q == ST_WARMUP) || (state_q == ST_RUN);
    rct_next = RctW'(1);
    if (have_prev_q && (bitIn == prev_bit_q)) begin
      rct_next = (rct_cnt_q == RctW'(RCTCutoff)) ? rct_cnt_q : rct_cnt_q + RctW'(1);
    end
    if (apt_pos_q == '0) begin
      apt_next = AptW'(1);
    end else if ((bitIn == apt_ref_q) && (apt_cnt_q != AptW'(APTCutoff))) begin
      apt_next = apt_cnt_q + AptW'(1);
    end else begin
      apt_next = apt_cnt_q;
    end
    health_fail = in_test && bitValid &&
                  ((rct_next == RctW'(RCTCutoff)) || (apt_next == AptW'(APTCutoff)));
  end

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    ctrl_rst_d   = 1'b0;
    rnd_valid_d  = 1'b0;
    rnd_bit_d    = rnd_bit_q;
    alarm_d      = alarm_q;
    alarm_code_d = alarm_code_q;
    restarts_d   = restarts_q;
    tmo_d        = '0;
    have_prev_d  = have_prev_q;
    prev_bit_d   = prev_bit_q;
    rct_cnt_d    = rct_cnt_q;
    apt_pos_d    = apt_pos_q;
    apt_ref_d    = apt_ref_q;
    apt_cnt_d    = apt_cnt_q;
    wu_cnt_d     = wu_cnt_q;

    if (in_test && bitValid) begin
      have_prev_d = 1'b1;
      prev_bit_d  = bitIn;
      rct_cnt_d   = rct_next;
      apt_pos_d   = apt_pos_q + APTWindowLog'(1);
      apt_ref_d   = (apt_pos_q == '0) ? bitIn : apt_ref_q;
      apt_cnt_d   = apt_next;
      if (wu_cnt_q != WuW'(WarmupSamples)) wu_cnt_d = wu_cnt_q + WuW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        ctrl_rst_d = 1'b1;
        if (start) begin
          state_d    = ST_MATCH;
          restarts_d = '0;
          ctrl_rst_d = 1'b0;
        end
      end
      ST_MATCH: begin
        // Health state is held cleared so each WARMUP entry starts fresh.
        have_prev_d = 1'b0;
        prev_bit_d  = 1'b0;
        rct_cnt_d   = '0;
        apt_pos_d   = '0;
        apt_ref_d   = 1'b0;
        apt_cnt_d   = '0;
        wu_cnt_d    = '0;
        if (noFound) begin
          state_d      = ST_FAIL;
          alarm_code_d = 2'd1;
        end else if (matched) begin
          state_d = ST_WARMUP;
        end else if (&tmo_q) begin
          state_d      = ST_FAIL;
          alarm_code_d = 2'd2;
        end else begin
          tmo_d = tmo_q + MatchTimeoutLog'(1);
        end
      end
      ST_WARMUP, ST_RUN: begin
        if ((state_q == ST_RUN) && bitValid && !health_fail) begin
          rnd_valid_d = 1'b1;
          rnd_bit_d   = bitIn;
        end
        if (health_fail) begin
          if (restarts_q == 2'(MaxRestarts - 1)) begin
            state_d      = ST_FAIL;
            alarm_code_d = 2'd3;
          end else begin
            restarts_d = restarts_q + 2'd1;
            ctrl_rst_d = 1'b1;
            state_d    = ST_MATCH;
          end
        end else if (!matched) begin
          state_d = ST_MATCH;
        end else if ((state_q == ST_WARMUP) && (wu_cnt_d == WuW'(WarmupSamples))) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_FAIL;
      end
    endcase

    if (state_d == ST_FAIL) begin
      ctrl_rst_d = 1'b1;
      alarm_d    = 1'b1;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ctrl_rst_q   <= 1'b1;
      rnd_valid_q  <= 1'b0;
      rnd_bit_q    <= 1'b0;
      alarm_q      <= 1'b0;
      alarm_code_q <= 2'd0;
      restarts_q   <= 2'd0;
      tmo_q        <= '0;
      have_prev_q  <= 1'b0;
      prev_bit_q   <= 1'b0;
      rct_cnt_q    <= '0;
      apt_pos_q    <= '0;
      apt_ref_q    <= 1'b0;
      apt_cnt_q    <= '0;
      wu_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_rst_q   <= ctrl_rst_d;
      rnd_valid_q  <= rnd_valid_d;
      rnd_bit_q    <= rnd_bit_d;
      alarm_q      <= alarm_d;
      alarm_code_q <= alarm_code_d;
      restarts_q   <= restarts_d;
      tmo_q        <= tmo_d;
      have_prev_q  <= have_prev_d;
      prev_bit_q   <= prev_bit_d;
      rct_cnt_q    <= rct_cnt_d;
      apt_pos_q    <= apt_pos_d;
      apt_ref_q    <= apt_ref_d;
      apt_cnt_q    <= apt_cnt_d;
      wu_cnt_q     <= wu_cnt_d;
    end
  end

  assign ctrlRst   = ctrl_rst_q;
  assign rndValid  = rnd_valid_q;
  assign rndBit    = rnd_bit_q;
  assign alarm     = alarm_q;
  assign alarmCode = alarm_code_q;
  assign state     = state_q;
  assign restarts  = restarts_q;

endmodule

// File: tb/tb_coso_sequencer.sv
// Bench for coso_sequencer: directed scenarios followed by random stimulus,
// checked against a bit-history reference model and an output scoreboard.
module tb_coso_sequencer;

  localparam int TmoLog = 4;
  localparam int RCT    = 8;
  localparam int WIN    = 64;
  localparam int APT    = 48;
  localparam int WU     = 16;
  localparam int MAXR   = 3;

  // Clock and reset block
  logic clk = 1'b0;
  logic rst, start, matched, noFound, bitValid, bitIn;
  logic ctrlRst, rndValid, rndBit, alarm;
  logic [1:0] alarmCode, restarts;
  logic [2:0] state;

  always #5 clk = ~clk;

  coso_sequencer #(.MatchTimeoutLog(TmoLog)) dut (
    .clk(clk), .rst(rst), .start(start), .matched(matched), .noFound(noFound),
    .bitValid(bitValid), .bitIn(bitIn), .ctrlRst(ctrlRst), .rndValid(rndValid),
    .rndBit(rndBit), .alarm(alarm), .alarmCode(alarmCode), .state(state),
    .restarts(restarts)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  // Reference model: state number, counters and bit history since WARMUP entry
  int m_state, m_restarts, m_code, m_ctrl, m_match_cyc;
  int hist[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RCT fails when the last RCT bits since entry are all identical.
  function automatic bit rct_fails();
    int n = hist.size();
    if (n < RCT) return 1'b0;
    for (int i = n - RCT; i < n; i++) if (hist[i] != hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  // APT fails when the count of bits equal to the window's first bit hits APT.
  function automatic bit apt_fails();
    int n  = hist.size();
    int ws = ((n - 1) / WIN) * WIN;
    int c  = 0;
    for (int i = ws; i < n; i++) if (hist[i] == hist[ws]) c++;
    return (c == APT) && (hist[n-1] == hist[ws]);
  endfunction

  // Driver: apply one cycle of inputs, advance the model, check after the edge.
  task automatic tick(input logic r, input logic s, input logic m, input logic nf,
                      input logic bv, input logic b);
    bit fwd;
    bit fail;
    fwd  = 1'b0;
    fail = 1'b0;
    @(negedge clk);
    rst = r; start = s; matched = m; noFound = nf; bitValid = bv; bitIn = b;
    if (r) begin
      m_state = 0; m_restarts = 0; m_code = 0; m_ctrl = 1; m_match_cyc = 0;
      hist.delete();
    end else begin
      case (m_state)
        0: begin
          m_ctrl = 1;
          if (s) begin m_state = 1; m_restarts = 0; m_match_cyc = 0; m_ctrl = 0; end
        end
        1: begin
          m_ctrl = 0;
          m_match_cyc++;
          if (nf) begin m_state = 4; m_code = 1; end
          else if (m) begin m_state = 2; hist.delete(); end
          else if (m_match_cyc == (1 << TmoLog)) begin m_state = 4; m_code = 2; end
        end
        2, 3: begin
          m_ctrl = 0;
          if (bv) begin
            hist.push_back(int'(b));
            fail = rct_fails() || apt_fails();
            if (!fail && m_state == 3) fwd = 1'b1;
          end
          if (fail) begin
            if (m_restarts == MAXR - 1) begin m_state = 4; m_code = 3; end
            else begin m_restarts++; m_state = 1; m_match_cyc = 0; m_ctrl = 1; end
          end else if (!m) begin
            m_state = 1; m_match_cyc = 0;
          end else if (m_state == 2 && hist.size() >= WU) begin
            m_state = 3;
          end
        end
        default: ;
      endcase
      if (m_state == 4) m_ctrl = 1;
    end
    @(posedge clk);
    #1;
    if (fwd) exp_q.push_back(b);
    chk("state", state, m_state);
    chk("ctrlRst", ctrlRst, m_ctrl);
    chk("alarm", alarm, (m_state == 4) ? 1 : 0);
    chk("alarmCode", alarmCode, m_code);
    chk("restarts", restarts, m_restarts);
  endtask

  // Monitor: every rndValid strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rndValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_rnd: got rndValid=1 expected no output (t=%0t)", $time);
      end else begin
        chk("rnd_bit", rndBit, exp_q.pop_front());
      end
    end else if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL missing_rnd: got rndValid=0 expected bit %0d (t=%0t)", exp_q[0], $time);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r, s, m, nf, bv, b;
    rst = 1'b1; start = 1'b0; matched = 1'b0; noFound = 1'b0; bitValid = 1'b0; bitIn = 1'b0;
    m_state = 0; m_restarts = 0; m_code = 0; m_ctrl = 1; m_match_cyc = 0;

    // Reset values and start ignored during rst
    repeat (2) tick(1, 0, 0, 0, 0, 0);
    chk("reset_rndValid", rndValid, 0);
    chk("reset_rndBit", rndBit, 0);
    tick(1, 1, 0, 0, 0, 0);
    chk("start_during_rst", state, 0);

    // Alternating bits: 16 warmup bits then RUN
    tick(0, 1, 0, 0, 0, 0);
    chk("start_to_match", state, 1);
    tick(0, 0, 1, 0, 0, 0);
    chk("matched_to_warmup", state, 2);
    for (int i = 0; i < 27; i++) begin
      tick(0, 0, 1, 0, 1, 1'(i % 2));
      if (i == 14) chk("still_warmup", state, 2);
      if (i == 15) chk("warmup_done", state, 3);
    end

    // Eight ones: the eighth fails RCT and is not forwarded
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 0, 1, 1'b1);
    chk("rct_restart_state", state, 1);
    chk("rct_restart_ctrl", ctrlRst, 1);
    chk("rct_restart_cnt", restarts, 1);
    tick(0, 0, 1, 0, 0, 0);
    chk("ctrl_pulse_one_cycle", ctrlRst, 0);

    // APT: 48 ones in pattern 1110, fails at bit 63
    for (int i = 0; i < 63; i++) tick(0, 0, 1, 0, 1, 1'((i % 4) != 3));
    chk("apt48_state", state, 1);
    chk("apt48_restarts", restarts, 2);
    tick(0, 0, 1, 0, 0, 0);

    // APT: 47 ones in the window, no failure
    for (int i = 0; i < 64; i++) tick(0, 0, 1, 0, 1, 1'(((i % 4) != 3) && (i != 62)));
    chk("apt47_state", state, 3);

    // Third failure -> FAIL, code 3; start ignored; rst recovers
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 0, 1, 1'b1);
    chk("third_fail_state", state, 4);
    chk("third_fail_code", alarmCode, 3);
    tick(0, 1, 1, 0, 0, 0);
    chk("fail_start_ignored", state, 4);
    tick(1, 0, 0, 0, 0, 0);
    chk("fail_rst_alarm", alarm, 0);

    // noFound in MATCH
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    chk("nofound_code", alarmCode, 1);
    tick(1, 0, 0, 0, 0, 0);

    // Match timeout after 16 MATCH cycles
    tick(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick(0, 0, 0, 0, 0, 0);
    chk("timeout_not_yet", state, 1);
    tick(0, 0, 0, 0, 0, 0);
    chk("timeout_code", alarmCode, 2);
    tick(1, 0, 0, 0, 0, 0);

    // matched drop coincides with an RCT failure: restart wins
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) tick(0, 0, 1, 0, 1, 1'(1 - (i % 2)));
    for (int i = 0; i < 7; i++) tick(0, 0, 1, 0, 1, 1'b1);
    tick(0, 0, 0, 0, 1, 1'b1);
    chk("drop_fail_restarts", restarts, 1);
    chk("drop_fail_ctrl", ctrlRst, 1);

    // rst mid-RUN
    tick(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 19; i++) tick(0, 0, 1, 0, 1, 1'(i % 2));
    chk("pre_rst_run", state, 3);
    tick(1, 0, 1, 0, 1, 1'b1);
    chk("midrun_rst_rndValid", rndValid, 0);
    chk("midrun_rst_rndBit", rndBit, 0);

    // Random stimulus
    for (int c = 0; c < 4000; c++) begin
      r = 1'b0; s = 1'b0; m = 1'b1; nf = 1'b0;
      bv = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom_range(0, 1));
      case (m_state)
        0: s = ($urandom_range(0, 3) == 0);
        1: begin
          m  = ($urandom_range(0, 3) == 0);
          nf = ($urandom_range(0, 99) == 0);
        end
        2, 3: if (!bv && $urandom_range(0, 49) == 0) m = 1'b0;
        default: r = ($urandom_range(0, 9) == 0);
      endcase
      if ($urandom_range(0, 999) == 0) r = 1'b1;
      tick(r, s, m, nf, bv, b);
    end

    tick(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
